// File: rtl/bp_update.sv
// Branch-predictor update engine: queues resolved branches and applies a 2-bit
// saturating read-modify-write to bp_cache. Optional stats via BP_UPDATE_STATS_EN.
module bp_update #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter logic [1:0]  CTR_TAKEN_INIT  = 2'b10,
  parameter logic [1:0]  CTR_NTAKEN_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic [31:0] cache_ra,
  input  logic [31:0] cache_dout,
  input  logic        cache_hit,
  output logic [31:0] cache_wa,
  output logic [31:0] cache_din,
  output logic        cache_we,
  output logic        busy
`ifdef BP_UPDATE_STATS_EN
  ,
  output logic [15:0] upd_count,
  output logic [15:0] alloc_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [32:0]     mem_q [FIFO_DEPTH];
  logic [32:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            hit_q, hit_d;
  logic            cache_we_q, cache_we_d;
  logic [31:0]     cache_ra_q, cache_ra_d;
  logic [31:0]     cache_wa_q, cache_wa_d;
  logic [31:0]     cache_din_q, cache_din_d;
  logic            upd_ready_q, upd_ready_d;
  logic            busy_q, busy_d;
`ifdef BP_UPDATE_STATS_EN
  logic [15:0]     upd_count_q, upd_count_d;
  logic [15:0]     alloc_count_q, alloc_count_d;
`endif

  logic            push;
  logic            pop;
  logic [32:0]     head;
  logic [AW:0]     remain;
  logic [31:0]     next_pc;
  logic [1:0]      new_ctr;
  logic            unused_s;

  // 2-bit saturating counter update; a miss allocates from the init values
  function automatic logic [1:0] next_ctr(input logic hit, input logic [1:0] ctr,
                                          input logic taken);
    logic [1:0] r;
    if (hit) begin
      if (taken) begin
        r = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      end else begin
        r = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
      end
    end else begin
      r = taken ? CTR_TAKEN_INIT : CTR_NTAKEN_INIT;
    end
    return r;
  endfunction

  assign unused_s = ^{cache_dout[31:2], hit_q};

  // Next-state logic for the queue, FSM and registered outputs
  always_comb begin
    push    = upd_valid && upd_ready_q;
    pop     = (state_q == WRITE);
    head    = mem_q[rd_ptr_q];
    new_ctr = next_ctr(cache_hit, cache_dout[1:0], head[0]);

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {upd_pc, upd_taken};
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // Head after this edge; an entry pushed into an otherwise empty queue bypasses the array
    remain  = pop ? count_q - (AW+1)'(1) : count_q;
    next_pc = (remain == '0) ? upd_pc : mem_q[rd_ptr_d][32:1];

    case (state_q)
      IDLE:    state_d = (count_q != '0) ? LOOKUP : IDLE;
      LOOKUP:  state_d = WRITE;
      WRITE:   state_d = (count_d != '0) ? LOOKUP : IDLE;
      default: state_d = IDLE;
    endcase

    hit_d       = (state_q == LOOKUP) ? cache_hit : hit_q;
    cache_we_d  = (state_d == WRITE);
    cache_wa_d  = (state_d == WRITE)  ? head[32:1] : 32'd0;
    cache_din_d = (state_d == WRITE)  ? {30'd0, new_ctr} : 32'd0;
    cache_ra_d  = (state_d == LOOKUP) ? next_pc : 32'd0;
    upd_ready_d = (count_d != FULL_CNT);
    busy_d      = (count_d != '0) || (state_d != IDLE);

`ifdef BP_UPDATE_STATS_EN
    upd_count_d   = pop ? upd_count_q + 16'd1 : upd_count_q;
    alloc_count_d = (pop && !hit_q) ? alloc_count_q + 16'd1 : alloc_count_q;
`endif
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hit_q       <= 1'b0;
      cache_we_q  <= 1'b0;
      cache_ra_q  <= 32'd0;
      cache_wa_q  <= 32'd0;
      cache_din_q <= 32'd0;
      upd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
`ifdef BP_UPDATE_STATS_EN
      upd_count_q   <= 16'd0;
      alloc_count_q <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hit_q       <= hit_d;
      cache_we_q  <= cache_we_d;
      cache_ra_q  <= cache_ra_d;
      cache_wa_q  <= cache_wa_d;
      cache_din_q <= cache_din_d;
      upd_ready_q <= upd_ready_d;
      busy_q      <= busy_d;
`ifdef BP_UPDATE_STATS_EN
      upd_count_q   <= upd_count_d;
      alloc_count_q <= alloc_count_d;
`endif
    end
  end

  // Reset must suppress a write already scheduled for this edge
  assign cache_we  = cache_we_q && reset;
  assign cache_ra  = cache_ra_q;
  assign cache_wa  = cache_wa_q;
  assign cache_din = cache_din_q;
  assign upd_ready = upd_ready_q;
  assign busy      = busy_q;
`ifdef BP_UPDATE_STATS_EN
  assign upd_count   = upd_count_q;
  assign alloc_count = alloc_count_q;
`endif

endmodule

// File: doc/bp_update.md
BP_UPDATE -- requirements
Module: bp_update

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the depth of the pending-update queue (power of two, at least 2).
REQ-002 Parameter CTR_TAKEN_INIT, default 2'b10, is the counter value allocated on a cache miss with a taken branch.
REQ-003 Parameter CTR_NTAKEN_INIT, default 2'b01, is the counter value allocated on a cache miss with a not-taken branch.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 upd_valid  input  1  a resolved-branch update is offered.
REQ-007 upd_ready  output  1  the update queue can accept an update.
REQ-008 upd_pc  input  32  PC of the resolved branch.
REQ-009 upd_taken  input  1  resolved direction; 1 means taken.
REQ-010 cache_ra  output  32  read address to the bp_cache read port.
REQ-011 cache_dout  input  32  bp_cache read data, valid in the same cycle as cache_ra (combinational read).
REQ-012 cache_hit  input  1  bp_cache hit for cache_ra, valid in the same cycle.
REQ-013 cache_wa  output  32  bp_cache write address.
REQ-014 cache_din  output  32  bp_cache write data: counter in bits [1:0], bits [31:2] zero.
REQ-015 cache_we  output  1  bp_cache write enable; the write commits on the same rising edge.
REQ-016 busy  output  1  high while the queue is non-empty or the FSM is not IDLE.

Function
REQ-017 An update SHALL be accepted on a rising edge where upd_valid=1 and upd_ready=1, and pushed to the queue tail as {upd_pc, upd_taken}.
REQ-018 upd_ready SHALL equal NOT full, depending only on registered queue state; a push is refused when the queue is full, even if a pop occurs in the same cycle.
REQ-019 A simultaneous push and pop on a non-full queue SHALL leave the occupancy unchanged and preserve FIFO order.
REQ-020 The FSM states SHALL be IDLE, LOOKUP and WRITE.
REQ-021 IDLE->LOOKUP when the queue is non-empty; otherwise the FSM stays in IDLE.
REQ-022 In LOOKUP, cache_ra SHALL equal the head PC, and cache_dout[1:0] and cache_hit SHALL be registered; LOOKUP->WRITE unconditionally.
REQ-023 In WRITE, cache_we=1 and cache_wa=head PC; the head is popped; WRITE->LOOKUP if another entry remains after the pop, else WRITE->IDLE.
REQ-024 Hit update: taken increments the counter and saturates at 2'b11; not-taken decrements it and saturates at 2'b00.
REQ-025 Miss update: the entry is allocated with CTR_TAKEN_INIT if taken, else CTR_NTAKEN_INIT.
REQ-026 Throughput is one update per 2 cycles; latency from acceptance into an empty queue while IDLE to cache_we is 3 cycles (IDLE, LOOKUP, WRITE).
REQ-027 Back-to-back updates to the same PC SHALL be serialized, so the second LOOKUP observes the first WRITE's result.
REQ-028 cache_we SHALL be 0 in every state except WRITE; cache_ra and cache_wa SHALL be 0 when they are unused.
REQ-029 Queue pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 When reset=0 at a rising edge: FSM->IDLE, queue emptied, cache_we=0, busy=0, upd_ready=1, all address and data outputs 0.
REQ-031 Reset asserted mid-operation (LOOKUP or WRITE) SHALL abort the operation with no write, and SHALL discard all queued updates.
REQ-032 No update is accepted on an edge where reset=0.

Configuration
REQ-033 Macro BP_UPDATE_STATS_EN: when defined, add outputs upd_count[15:0] (increments on every WRITE) and alloc_count[15:0] (increments on every WRITE that follows a miss); both wrap at 16'hFFFF->0 and reset to 0.
REQ-034 When BP_UPDATE_STATS_EN is undefined, these ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Empty cache (hit=0), push pc=0xA0 taken=1 -> three cycles later cache_we=1, cache_wa=0xA0, cache_din=0x00000002.
REQ-036 Cache model holds 0xA0 with counter 2'b11, push 0xA0 taken=1 -> cache_din=0x00000003 (saturate); push 0xA0 taken=0 -> cache_din=0x00000002.
REQ-037 Push 0xA0 taken=1 twice back-to-back on an empty cache -> writes 0x2 then 0x3, in order.
REQ-038 Hold cache_hit=0 and push with upd_valid held high -> exactly FIFO_DEPTH+1 accepted before the first upd_ready=0, and no update is lost or duplicated.
REQ-039 Assert reset during WRITE with 3 entries queued -> no cache_we in that cycle, busy=0 and upd_ready=1 after the edge.
REQ-040 With BP_UPDATE_STATS_EN, 2 misses followed by 1 hit -> upd_count=3, alloc_count=2.
